// File: rtl/ifetch_buf.sv
// Instruction fetch front end. It issues sequential icache requests, limited by credit to DEPTH
// in-order responses in flight, and queues them as {instr, pc} for DEC. A flush redirects fetch.
module ifetch_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] reset_adr_i,
  output logic            icache_req_v_o,
  output logic [XLEN-1:0] icache_adr_o,
  input  logic            icache_req_rdy_i,
  input  logic            icache_rsp_v_i,
  input  logic [31:0]     icache_instr_i,
  input  logic            flush_v_q_i,
  input  logic [XLEN-1:0] pc_data_q_i,
  input  logic            dec_rdy_i,
  output logic            instr_v_q_o,
  output logic [31:0]     instr_q_o,
  output logic [XLEN-1:0] pc_q_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

  logic            started_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [CW-1:0]   out_cnt_q;
  logic [CW-1:0]   disc_cnt_q;
  logic [CW-1:0]   fifo_cnt_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [31:0]     mem_instr_q [DEPTH];
  logic [XLEN-1:0] mem_pc_q    [DEPTH];

  logic        req_fire;
  logic        rsp_fire;
  logic        drop;
  logic        push;
  logic        pop;
  logic [CW:0] credit_used;

  // Queued entries plus requests in flight never exceed DEPTH, so a push always finds room.
  assign credit_used    = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q};
  assign icache_req_v_o = started_q & ~flush_v_q_i & (credit_used < DEPTH_C);
  assign icache_adr_o   = fetch_pc_q;
  assign req_fire       = icache_req_v_o & icache_req_rdy_i;

  // A response with nothing in flight is ignored.
  assign rsp_fire = icache_rsp_v_i & (out_cnt_q != '0);
  assign drop     = rsp_fire & (disc_cnt_q != '0);
  assign push     = rsp_fire & ~drop & ~flush_v_q_i;

  assign instr_v_q_o = (fifo_cnt_q != '0);
  assign pop         = instr_v_q_o & dec_rdy_i & ~flush_v_q_i;
  assign instr_q_o   = mem_instr_q[rd_ptr_q];
  assign pc_q_o      = mem_pc_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started_q  <= 1'b0;
      fetch_pc_q <= '0;
      rsp_pc_q   <= '0;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      out_cnt_q <= out_cnt_q + CW'(req_fire) - CW'(rsp_fire);
      if (flush_v_q_i) begin
        // Everything still in flight after this cycle belongs to the old path.
        started_q  <= 1'b1;
        fetch_pc_q <= pc_data_q_i;
        rsp_pc_q   <= pc_data_q_i;
        disc_cnt_q <= out_cnt_q - CW'(rsp_fire);
        fifo_cnt_q <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else if (!started_q) begin
        started_q  <= 1'b1;
        fetch_pc_q <= reset_adr_i;
        rsp_pc_q   <= reset_adr_i;
      end else begin
        if (req_fire) fetch_pc_q <= fetch_pc_q + PC_STEP;
        if (drop)     disc_cnt_q <= disc_cnt_q - CNT_ONE;
        if (push) begin
          rsp_pc_q <= rsp_pc_q + PC_STEP;
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else if (push) begin
      mem_instr_q[wr_ptr_q] <= icache_instr_i;
      mem_pc_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

endmodule
